stream_protocol_monitor: RTL and testbench

- Synthesizable, parametrised protocol monitor for valid/ready streaming interfaces, sitting beside the filter datapath.
- Successor to the simulation-only X-check module: it watches CHANNELS independent ext-style stream ports (valid, ready, data) at runtime.
- Flags handshake violations and stall timeouts per channel, keeps saturating transfer counters, and raises a sticky interrupt.
- Usable in silicon and in simulation.

---
 rtl/stream_protocol_monitor.sv | 165 ++++++++++++++++
 tb/tb_stream_protocol_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_protocol_monitor.sv
// Purpose: runtime handshake checker for CHANNELS valid/ready streams; sticky error flags, transfer counters, irq.
// Latency: flags, first-error capture and counters update on the sampling edge; irq_out follows one edge later.
// Backpressure: passive observer, never stalls the monitored streams; clr_in discards same-cycle events.
module stream_protocol_monitor #(
    parameter  int CHANNELS = 2,
    parameter  int DATABITS = 16,
    parameter  int TIMEOUT  = 64,
    parameter  int CNTBITS  = 8,
    localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          valid_in,
    input  logic [CHANNELS-1:0]          ready_in,
    input  logic [CHANNELS*DATABITS-1:0] data_in,
    input  logic                         clr_in,
    input  logic [SELW-1:0]              sel_in,
    output logic [CHANNELS-1:0]          err_drop_out,
    output logic [CHANNELS-1:0]          err_change_out,
    output logic [CHANNELS-1:0]          err_timeout_out,
    output logic                         irq_out,
    output logic [SELW-1:0]              first_ch_out,
    output logic                         first_vld_out,
    output logic [CNTBITS-1:0]           count_out
);

    // stall counter must be able to hold the value TIMEOUT itself
    localparam int STW = $clog2(TIMEOUT + 1);

    logic [CHANNELS-1:0] r_stall_q;
    logic [DATABITS-1:0] r_hold      [CHANNELS];
    logic [STW-1:0]      r_stall_cnt [CHANNELS];
    logic [CNTBITS-1:0]  r_xfer_cnt  [CHANNELS];
    logic [CHANNELS-1:0] r_err_drop;
    logic [CHANNELS-1:0] r_err_change;
    logic [CHANNELS-1:0] r_err_timeout;
    logic                r_irq;
    logic [SELW-1:0]     r_first_ch;
    logic                r_first_vld;

    logic [DATABITS-1:0] w_data [CHANNELS];
    logic [CHANNELS-1:0] w_stalled;
    logic [CHANNELS-1:0] w_xfer;
    logic [CHANNELS-1:0] w_new_drop;
    logic [CHANNELS-1:0] w_new_change;
    logic [CHANNELS-1:0] w_new_timeout;
    logic [CHANNELS-1:0] w_evt;
    logic [SELW-1:0]     w_first_idx;

    // per-channel violation detection for the current sample
    always_comb begin
        w_stalled     = valid_in & ~ready_in;
        w_xfer        = valid_in & ready_in;
        w_new_drop    = '0;
        w_new_change  = '0;
        w_new_timeout = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_data[c]        = data_in[c*DATABITS +: DATABITS];
            w_new_drop[c]    = r_stall_q[c] & ~valid_in[c];
            w_new_change[c]  = r_stall_q[c] & valid_in[c] & (w_data[c] != r_hold[c]);
            // fires only on the sample that brings the count to TIMEOUT; it then holds there
            w_new_timeout[c] = w_stalled[c] & (r_stall_cnt[c] == STW'(TIMEOUT - 1));
        end
        w_evt = w_new_drop | w_new_change | w_new_timeout;
    end

    // lowest-numbered channel with an event this sample
    always_comb begin
        w_first_idx = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_evt[c]) begin
                w_first_idx = SELW'(c);
            end
        end
    end

    // stall tracking: previous-stall bit, held data and saturating stall length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_hold[c]      <= '0;
                r_stall_cnt[c] <= '0;
            end
        end else begin
            r_stall_q <= clr_in ? '0 : w_stalled;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_stalled[c]) begin
                    r_hold[c] <= w_data[c];
                end
                if (clr_in || !w_stalled[c]) begin
                    r_stall_cnt[c] <= '0;
                end else if (r_stall_cnt[c] != STW'(TIMEOUT)) begin
                    r_stall_cnt[c] <= r_stall_cnt[c] + STW'(1);
                end
            end
        end
    end

    // saturating transfer counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_xfer_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (clr_in) begin
                    r_xfer_cnt[c] <= '0;
                end else if (w_xfer[c] && (r_xfer_cnt[c] != {CNTBITS{1'b1}})) begin
                    r_xfer_cnt[c] <= r_xfer_cnt[c] + CNTBITS'(1);
                end
            end
        end
    end

    // sticky flags; irq is the registered OR of the already-registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_drop    <= '0;
            r_err_change  <= '0;
            r_err_timeout <= '0;
            r_irq         <= 1'b0;
        end else if (clr_in) begin
            r_err_drop    <= '0;
            r_err_change  <= '0;
            r_err_timeout <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_err_drop    <= r_err_drop    | w_new_drop;
            r_err_change  <= r_err_change  | w_new_change;
            r_err_timeout <= r_err_timeout | w_new_timeout;
            r_irq         <= |{r_err_drop, r_err_change, r_err_timeout};
        end
    end

    // first-error capture, frozen until clear; the channel number survives clear but is not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_ch  <= '0;
            r_first_vld <= 1'b0;
        end else if (clr_in) begin
            r_first_vld <= 1'b0;
        end else if (!r_first_vld && (|w_evt)) begin
            r_first_ch  <= w_first_idx;
            r_first_vld <= 1'b1;
        end
    end

    // counter readback; an out-of-range select reads as zero
    always_comb begin
        count_out = '0;
        if (32'(sel_in) < CHANNELS) begin
            count_out = r_xfer_cnt[sel_in];
        end
    end

    assign err_drop_out    = r_err_drop;
    assign err_change_out  = r_err_change;
    assign err_timeout_out = r_err_timeout;
    assign irq_out         = r_irq;
    assign first_ch_out    = r_first_ch;
    assign first_vld_out   = r_first_vld;

endmodule

// File: tb/tb_stream_protocol_monitor.sv
// Bench for stream_protocol_monitor: directed test-plan steps followed by random traffic.
// Expected values come from constants and a rule-level model of per-channel stream behaviour.
// Inputs are driven just after each rising edge; outputs are checked 1 time unit after it.
module tb_stream_protocol_monitor;

    localparam int CH  = 2;
    localparam int DB  = 16;
    localparam int TO  = 4;
    localparam int CB  = 4;
    localparam int CMAX = (1 << CB) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   valid_in = '0;
    logic [CH-1:0]   ready_in = '0;
    logic [CH*DB-1:0] data_in = '0;
    logic            clr_in = 1'b0;
    logic [0:0]      sel_in = '0;
    logic [CH-1:0]   err_drop_out;
    logic [CH-1:0]   err_change_out;
    logic [CH-1:0]   err_timeout_out;
    logic            irq_out;
    logic [0:0]      first_ch_out;
    logic            first_vld_out;
    logic [CB-1:0]   count_out;

    int checks = 0;
    int failures = 0;

    // behavioural model: stall run lengths, held words, flags, counts
    int       m_run  [CH];
    bit       m_prev [CH];
    int       m_hold [CH];
    int       m_cnt  [CH];
    bit [CH-1:0] m_drop, m_chg, m_to;
    int       m_first_ch;
    bit       m_first_vld;
    bit       m_irq;

    stream_protocol_monitor #(
        .CHANNELS(CH), .DATABITS(DB), .TIMEOUT(TO), .CNTBITS(CB)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .data_in(data_in), .clr_in(clr_in), .sel_in(sel_in),
        .err_drop_out(err_drop_out), .err_change_out(err_change_out),
        .err_timeout_out(err_timeout_out), .irq_out(irq_out),
        .first_ch_out(first_ch_out), .first_vld_out(first_vld_out),
        .count_out(count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_prev[c] = 0; m_hold[c] = 0; m_cnt[c] = 0;
        end
        m_drop = '0; m_chg = '0; m_to = '0;
        m_first_ch = 0; m_first_vld = 0; m_irq = 0;
    endtask

    // one sample of the stream rules, applied to the inputs present before the edge
    task automatic model_step();
        bit any_old;
        bit captured;
        any_old = |{m_drop, m_chg, m_to};
        if (clr_in) begin
            for (int c = 0; c < CH; c++) begin
                m_run[c] = 0; m_prev[c] = 0; m_cnt[c] = 0;
                if (valid_in[c] && !ready_in[c]) m_hold[c] = int'(data_in[c*DB +: DB]);
            end
            m_drop = '0; m_chg = '0; m_to = '0;
            m_first_vld = 0; m_irq = 0;
            return;
        end
        captured = 0;
        for (int c = 0; c < CH; c++) begin
            bit v, r, st, e_drop, e_chg, e_to;
            int d;
            v = valid_in[c]; r = ready_in[c]; st = v && !r;
            d = int'(data_in[c*DB +: DB]);
            e_drop = m_prev[c] && !v;
            e_chg  = m_prev[c] && v && (d != m_hold[c]);
            e_to   = st && (m_run[c] + 1 == TO);
            m_run[c] = st ? ((m_run[c] + 1 > TO) ? TO : m_run[c] + 1) : 0;
            if (v && r && m_cnt[c] < CMAX) m_cnt[c]++;
            if (st) m_hold[c] = d;
            m_prev[c] = st;
            if (e_drop) m_drop[c] = 1;
            if (e_chg)  m_chg[c] = 1;
            if (e_to)   m_to[c] = 1;
            if (!m_first_vld && !captured && (e_drop || e_chg || e_to)) begin
                m_first_ch = c;
                captured = 1;
            end
        end
        if (captured) m_first_vld = 1;
        m_irq = any_old;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".drop"},   32'(err_drop_out),    32'(m_drop));
        check({tag, ".chg"},    32'(err_change_out),  32'(m_chg));
        check({tag, ".to"},     32'(err_timeout_out), 32'(m_to));
        check({tag, ".irq"},    32'(irq_out),         32'(m_irq));
        check({tag, ".fvld"},   32'(first_vld_out),   32'(m_first_vld));
        check({tag, ".fch"},    32'(first_ch_out),    32'(m_first_ch));
        check({tag, ".count"},  32'(count_out),       32'(m_cnt[sel_in]));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic drive(input int c, input bit v, input bit r, input int d);
        valid_in[c] = v;
        ready_in[c] = r;
        data_in[c*DB +: DB] = DB'(d);
    endtask

    task automatic do_clear();
        clr_in = 1'b1;
        tick("clear");
        clr_in = 1'b0;
    endtask

    initial begin
        model_reset();
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.drop", 32'(err_drop_out), 0);
        check("rst.irq", 32'(irq_out), 0);
        check("rst.fvld", 32'(first_vld_out), 0);
        check("rst.count", 32'(count_out), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_model("idle");

        // clean traffic on ch0: 3 stalled samples then a transfer, data stable
        sel_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (3) begin
                drive(0, 1, 0, 16'h100 + i);
                tick("clean.stall");
            end
            drive(0, 1, 1, 16'h100 + i);
            tick("clean.xfer");
        end
        drive(0, 0, 0, 0);
        tick("clean.idle");
        check("clean.count10", 32'(count_out), 10);
        check("clean.flags", 32'({err_drop_out, err_change_out, err_timeout_out}), 0);
        check("clean.irq", 32'(irq_out), 0);
        do_clear();

        // drop on ch1
        drive(1, 1, 0, 16'h55);
        tick("drop.s1");
        tick("drop.s2");
        drive(1, 0, 0, 16'h55);
        tick("drop.fall");
        check("drop.flag", 32'(err_drop_out), 32'h2);
        check("drop.irq_late", 32'(irq_out), 0);
        check("drop.fch", 32'(first_ch_out), 1);
        check("drop.fvld", 32'(first_vld_out), 1);
        tick("drop.after");
        check("drop.irq", 32'(irq_out), 1);
        do_clear();

        // data change on ch0 while stalled
        drive(0, 1, 0, 16'h00A5);
        tick("chg.s1");
        drive(0, 1, 0, 16'h00A6);
        tick("chg.s2");
        check("chg.flag", 32'(err_change_out), 32'h1);
        check("chg.nodrop", 32'(err_drop_out), 0);
        // the drop sampled together with clear must be discarded
        drive(0, 0, 0, 0);
        do_clear();
        check("chg.cleared", 32'({err_drop_out, err_change_out}), 0);

        // timeout: 10 stalled samples then a stable transfer
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 0, 16'h1234);
            tick("to.stall");
            if (i == 3) check("to.before", 32'(err_timeout_out), 0);
            if (i == 4) check("to.at4", 32'(err_timeout_out), 1);
        end
        drive(0, 1, 1, 16'h1234);
        tick("to.xfer");
        check("to.legal", 32'({err_drop_out, err_change_out}), 0);
        check("to.fch", 32'(first_ch_out), 0);
        drive(0, 0, 0, 0);
        do_clear();

        // saturation on ch1
        sel_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, i);
            tick("sat.xfer");
        end
        check("sat.count15", 32'(count_out), 15);
        // clear wins over a violation and a transfer in the same sample
        drive(1, 1, 0, 7);
        tick("clrv.stall");
        drive(1, 0, 0, 7);
        drive(0, 1, 1, 3);
        do_clear();
        check("clrv.flags", 32'({err_drop_out, err_change_out, err_timeout_out}), 0);
        check("clrv.count", 32'(count_out), 0);
        check("clrv.fvld", 32'(first_vld_out), 0);
        drive(0, 0, 0, 0);
        tick("clrv.idle");
        check("clrv.irq", 32'(irq_out), 0);
        // fresh violation recaptures
        drive(1, 1, 0, 9);
        tick("recap.stall");
        drive(1, 0, 0, 9);
        tick("recap.drop");
        check("recap.fch", 32'(first_ch_out), 1);
        check("recap.fvld", 32'(first_vld_out), 1);
        do_clear();

        // simultaneous drops: lowest index wins
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 2);
        tick("sim.stall");
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 2);
        tick("sim.drop");
        check("sim.flags", 32'(err_drop_out), 32'h3);
        check("sim.fch", 32'(first_ch_out), 0);
        do_clear();

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                drive(c, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 2)));
            end
            clr_in = ($urandom_range(0, 29) == 0);
            sel_in = 1'($urandom_range(0, 1));
            tick("rand");
        end
        clr_in = 1'b0;
        do_clear();

        // async reset mid-stall on ch1
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 16'hBEEF);
        tick("ars.s1");
        tick("ars.s2");
        rst = 1'b1;
        model_reset();
        #1;
        check_model("ars.inrst");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0);
        tick("ars.post");
        check("ars.nodrop", 32'(err_drop_out), 0);
        check("ars.irq", 32'(irq_out), 0);
        tick("ars.post2");
        check("ars.irq2", 32'(irq_out), 0);
        check("ars.fvld", 32'(first_vld_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
